// File: rtl/lc3_dmem_responder_pkg.sv
// Shared definitions for the LC3 data-memory responder.
//   mem_state_e  : request codes driven by the pipeline controller
//   resp_state_e : responder FSM states
//   is_request() : true for codes that start an access (read, pointer read, write)
package lc3_dmem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_RD   = 3'd0,
    MEM_IND  = 3'd1,
    MEM_WR   = 3'd2,
    MEM_IDLE = 3'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_e;

  // Codes 3..7 all mean "nothing to do".
  function automatic logic is_request(input logic [2:0] code);
    return (code <= 3'd2);
  endfunction

endpackage

// File: rtl/lc3_dmem_responder_if.sv
// Request/response bus between the LC3 pipeline controller and the
// data-memory responder.
//   master : controller side (drives mem_state, M_Addr, M_Data)
//   slave  : responder side (drives complete_data, memout, busy, ind_pending)
interface lc3_dmem_responder_if;
  logic [2:0]  mem_state;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic        complete_data;
  logic [15:0] memout;
  logic        busy;
  logic        ind_pending;

  modport master (
    output mem_state, M_Addr, M_Data,
    input  complete_data, memout, busy, ind_pending
  );

  modport slave (
    input  mem_state, M_Addr, M_Data,
    output complete_data, memout, busy, ind_pending
  );
endinterface

// File: rtl/lc3_dmem_array.sv
// Single-port data array, 2**ADDR_W x 16 bits.
//   clk   : write clock
//   we    : write enable (synchronous write)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : combinational read data at addr
// Contents are deliberately not reset.
module lc3_dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: answers read / pointer-read / write requests
// from the pipeline controller after WAIT_CYCLES wait states and signals
// completion with a one-cycle complete_data pulse.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of lc3_dmem_responder_if
//
//   state | meaning
//   IDLE  | waiting for a request code 0/1/2
//   BUSY  | request latched, counting down wait states
//   DONE  | access performed on entry; complete_data high for this cycle
module lc3_dmem_responder
  import lc3_dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lc3_dmem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic       NO_WAIT = (WAIT_CYCLES == 0);

  resp_state_e       state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       ptr_q, ptr_d;
  logic [15:0]       memout_q, memout_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              cmp_q, cmp_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              use_ptr;
  logic              finish;
  logic [ADDR_W-1:0] eff_sel;
  logic [2:0]        op_now;
  logic [ADDR_W-1:0] addr_now;
  logic [15:0]       data_now;
  logic              arr_we;
  logic [15:0]       arr_rdata;
  logic              unused_bits;

  assign accept  = (state_q == IDLE) && is_request(bus.mem_state);
  // A pending pointer redirects the next plain read or write; a new
  // pointer read always goes to M_Addr.
  assign use_ptr = pend_q && (bus.mem_state != 3'(MEM_IND));
  assign eff_sel = use_ptr ? ptr_q[ADDR_W-1:0] : bus.M_Addr[ADDR_W-1:0];

  // With no wait states the access happens on the accepting edge, so the
  // array sees the live request rather than the latched copy.
  assign op_now   = accept ? bus.mem_state : op_q;
  assign addr_now = accept ? eff_sel       : addr_q;
  assign data_now = accept ? bus.M_Data    : data_q;
  assign finish   = (accept && NO_WAIT) || ((state_q == BUSY) && (cnt_q == 4'd1));
  assign arr_we   = finish && (op_now == 3'(MEM_WR));

  assign unused_bits = ^{bus.M_Addr[15:ADDR_W], ptr_q[15:ADDR_W]};

  lc3_dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (addr_now),
    .wdata (data_now),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    memout_d = memout_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.mem_state;
          addr_d  = eff_sel;
          data_d  = bus.M_Data;
          cnt_d   = WAIT_LD;
          if (use_ptr) pend_d = 1'b0;
          state_d = NO_WAIT ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      if (op_now == 3'(MEM_RD)) begin
        memout_d = arr_rdata;
      end else if (op_now == 3'(MEM_IND)) begin
        memout_d = arr_rdata;
        ptr_d    = arr_rdata;
        pend_d   = 1'b1;
      end
    end

    cmp_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= 3'(MEM_IDLE);
      addr_q   <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
      memout_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      cmp_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      memout_q <= memout_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      cmp_q    <= cmp_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.complete_data = cmp_q;
  assign bus.memout        = memout_q;
  assign bus.busy          = busy_q;
  assign bus.ind_pending   = pend_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: two instances (no wait states and two wait
// states) share one stimulus stream and are compared every cycle against a
// transaction-level model; directed sequences add literal cycle checks.
module tb_lc3_dmem_responder;

  localparam int WT [2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  ms  = 3'd3;
  logic [15:0] ma  = 16'h0;
  logic [15:0] md  = 16'h0;

  always #5 clk = ~clk;

  lc3_dmem_responder_if bus0 ();
  lc3_dmem_responder_if bus2 ();

  assign bus0.mem_state = ms;
  assign bus0.M_Addr    = ma;
  assign bus0.M_Data    = md;
  assign bus2.mem_state = ms;
  assign bus2.M_Addr    = ma;
  assign bus2.M_Data    = md;

  lc3_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lc3_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        o_busy [2];
  logic        o_cmp  [2];
  logic        o_pend [2];
  logic [15:0] o_mo   [2];
  assign o_busy[0] = bus0.busy;          assign o_busy[1] = bus2.busy;
  assign o_cmp[0]  = bus0.complete_data; assign o_cmp[1]  = bus2.complete_data;
  assign o_pend[0] = bus0.ind_pending;   assign o_pend[1] = bus2.ind_pending;
  assign o_mo[0]   = bus0.memout;        assign o_mo[1]   = bus2.memout;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int pulses2  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          cyc = 0;
  logic [15:0] m_mem    [2][256];
  bit          m_mv     [2][256];
  bit          m_active [2];
  int          m_done_at[2];
  logic [2:0]  m_op     [2];
  logic [7:0]  m_eff    [2];
  logic [15:0] m_dat    [2];
  logic [15:0] m_ptr    [2];
  bit          m_pend   [2];
  logic [15:0] m_mo     [2];
  bit          m_mo_ok  [2];
  bit          m_busy   [2];
  bit          m_cmp    [2];

  // A request seen in cycle c finishes with the pulse in cycle c+W+1;
  // the access itself lands on the edge that starts that cycle.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 0; m_pend[k] = 0; m_ptr[k] = 16'h0;
        m_mo[k] = 16'h0; m_mo_ok[k] = 1; m_busy[k] = 0; m_cmp[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_active[k] && m_done_at[k] == cyc) begin
          m_active[k] = 0;
        end else if (!m_active[k] && ms <= 3'd2) begin
          m_active[k]  = 1;
          m_op[k]      = ms;
          m_done_at[k] = cyc + WT[k] + 1;
          m_dat[k]     = md;
          if (m_pend[k] && ms != 3'd1) begin
            m_eff[k]  = m_ptr[k][7:0];
            m_pend[k] = 0;
          end else begin
            m_eff[k] = ma[7:0];
          end
        end
        if (m_active[k] && m_done_at[k] == cyc + 1) begin
          if (m_op[k] == 3'd2) begin
            m_mem[k][m_eff[k]] = m_dat[k];
            m_mv[k][m_eff[k]]  = 1;
          end else begin
            m_mo[k]    = m_mem[k][m_eff[k]];
            m_mo_ok[k] = m_mv[k][m_eff[k]];
            if (m_op[k] == 3'd1) begin
              m_ptr[k]  = m_mem[k][m_eff[k]];
              m_pend[k] = 1;
            end
          end
        end
        m_busy[k] = m_active[k];
        m_cmp[k]  = m_active[k] && (m_done_at[k] == cyc + 1);
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (bus2.complete_data) pulses2++;
    if (rst && chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk1($sformatf("busy_w%0d", WT[k]), o_busy[k], m_busy[k]);
        chk1($sformatf("complete_w%0d", WT[k]), o_cmp[k], m_cmp[k]);
        chk1($sformatf("ind_pending_w%0d", WT[k]), o_pend[k], m_pend[k]);
        if (m_mo_ok[k]) chk($sformatf("memout_w%0d", WT[k]), o_mo[k], m_mo[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d);
    ms = c; ma = a; md = d;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus0.busy || bus2.busy) && t < 60) begin
      step();
      t++;
    end
    if (t >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still high after %0d cycles", t);
    end
  endtask

  task automatic txn(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d);
    drv(c, a, d);
    step();
    drv(3'd3, 16'h0, 16'h0);
    wait_idle();
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[7:3] = 5'b0;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] codes [9];
    codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    drv(3'd3, 16'h0, 16'h0);
    repeat (3) step();
    chk1("reset_busy", bus2.busy, 1'b0);
    chk1("reset_complete", bus2.complete_data, 1'b0);
    chk1("reset_pending", bus2.ind_pending, 1'b0);
    chk("reset_memout", bus2.memout, 16'h0000);
    rst = 1'b1;
    chk_en = 1;
    step();

    txn(3'd2, 16'h0010, 16'hBEEF);
    txn(3'd2, 16'h0030, 16'h0044);
    txn(3'd2, 16'h0044, 16'hCAFE);
    txn(3'd2, 16'h0050, 16'h0066);
    txn(3'd2, 16'h0066, 16'h1111);
    txn(3'd2, 16'h0070, 16'h5555);
    for (int i = 0; i < 8; i++) txn(3'd2, 16'(i), rnd_word());

    // Read 0x10 with two wait states; request visible in cycle N.
    drv(3'd0, 16'h0010, 16'h0);
    chk1("rd_n_busy", bus2.busy, 1'b0);
    step(); drv(3'd3, 16'h0, 16'h0);
    chk1("rd_n1_busy", bus2.busy, 1'b1);
    chk1("rd_n1_cmp", bus2.complete_data, 1'b0);
    chk1("rd_w0_n1_cmp", bus0.complete_data, 1'b1);
    chk("rd_w0_n1_memout", bus0.memout, 16'hBEEF);
    step();
    chk1("rd_n2_busy", bus2.busy, 1'b1);
    chk1("rd_n2_cmp", bus2.complete_data, 1'b0);
    chk("rd_n2_memout", bus2.memout, 16'h0000);
    step();
    chk1("rd_n3_busy", bus2.busy, 1'b1);
    chk1("rd_n3_cmp", bus2.complete_data, 1'b1);
    chk("rd_n3_memout", bus2.memout, 16'hBEEF);
    step();
    chk1("rd_n4_busy", bus2.busy, 1'b0);
    chk1("rd_n4_cmp", bus2.complete_data, 1'b0);
    chk("rd_n4_memout", bus2.memout, 16'hBEEF);

    // Write then read back.
    pulses2 = 0;
    txn(3'd2, 16'h0020, 16'h1234);
    txn(3'd0, 16'h0020, 16'h0);
    chk("wr_rd_memout", bus2.memout, 16'h1234);
    chk("wr_rd_pulses", 16'(pulses2), 16'd2);

    // LDI: pointer read at 0x30, then plain read the cycle after the pulse.
    drv(3'd1, 16'h0030, 16'h0);
    step(); drv(3'd3, 16'h0, 16'h0);
    step();
    chk1("ldi_n2_pend", bus2.ind_pending, 1'b0);
    step();
    chk1("ldi_n3_cmp", bus2.complete_data, 1'b1);
    chk1("ldi_n3_pend", bus2.ind_pending, 1'b1);
    chk("ldi_n3_memout", bus2.memout, 16'h0044);
    step(); drv(3'd0, 16'h0999, 16'h0);
    chk1("ldi_n4_pend", bus2.ind_pending, 1'b1);
    step(); drv(3'd3, 16'h0, 16'h0);
    chk1("ldi_n5_pend", bus2.ind_pending, 1'b0);
    chk1("ldi_n5_busy", bus2.busy, 1'b1);
    wait_idle();
    chk("ldi_memout", bus2.memout, 16'hCAFE);

    // STI: pointer read at 0x50, then write through the pointer.
    drv(3'd1, 16'h0050, 16'h0);
    step(); drv(3'd3, 16'h0, 16'h0);
    step(); step();
    chk1("sti_n3_cmp", bus2.complete_data, 1'b1);
    step(); drv(3'd2, 16'h00F0, 16'hA5A5);
    step(); drv(3'd3, 16'h0, 16'h0);
    wait_idle();
    txn(3'd0, 16'h0066, 16'h0);
    chk("sti_target", bus2.memout, 16'hA5A5);
    txn(3'd0, 16'h0050, 16'h0);
    chk("sti_pointer_loc", bus2.memout, 16'h0066);

    // Reset clears a pending pointer.
    txn(3'd1, 16'h0030, 16'h0);
    chk1("pend_before_rst", bus2.ind_pending, 1'b1);
    rst = 1'b0; #1;
    chk1("pend_after_rst", bus2.ind_pending, 1'b0);
    chk("memout_after_rst", bus2.memout, 16'h0000);
    step(); step();
    rst = 1'b1;
    step();

    // Reset during BUSY of a write to 0x70.
    drv(3'd2, 16'h0070, 16'hFFFF);
    step(); drv(3'd3, 16'h0, 16'h0);
    chk1("rstw_busy_pre", bus2.busy, 1'b1);
    rst = 1'b0; #1;
    chk1("rstw_busy", bus2.busy, 1'b0);
    chk1("rstw_cmp", bus2.complete_data, 1'b0);
    chk("rstw_memout", bus2.memout, 16'h0000);
    chk1("rstw_pend", bus2.ind_pending, 1'b0);
    step();
    chk1("rstw_cmp_hold", bus2.complete_data, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk1("rstw_cmp_after", bus2.complete_data, 1'b0);
    txn(3'd0, 16'h0070, 16'h0);
    chk("rstw_array_kept", bus2.memout, 16'h5555);

    // Code 5 held: never accepted.
    drv(3'd5, 16'h0010, 16'h0);
    repeat (10) begin
      step();
      chk1("code5_busy_w2", bus2.busy, 1'b0);
      chk1("code5_busy_w0", bus0.busy, 1'b0);
    end
    drv(3'd3, 16'h0, 16'h0);

    // Address aliasing: 0x0110 reads 0x10.
    txn(3'd0, 16'h0110, 16'h0);
    chk("alias_memout", bus2.memout, 16'hBEEF);

    // Randomised traffic over a preloaded pool, with aliased upper bits.
    repeat (400) begin
      logic [15:0] a;
      a = 16'($urandom);
      a[7:3] = 5'b0;
      drv(codes[$urandom_range(0, 8)], a, rnd_word());
      step();
    end
    drv(3'd3, 16'h0, 16'h0);
    step();
    wait_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
